// File: rtl/e203_exu_bjp_resolve_pkg.sv
// rtl/e203_exu_bjp_resolve_pkg.sv - shared types and helpers for branch/jump resolution
`include "e203_defines.v"

package e203_exu_bjp_resolve_pkg;

    typedef enum logic [`E203_BJP_STATE_WIDTH-1:0] {
        BJP_IDLE  = `E203_BJP_STATE_IDLE,
        BJP_FLUSH = `E203_BJP_STATE_FLUSH
    } bjp_state_e;

    // Fall-through distance to the next instruction.
    function automatic logic [`E203_PC_SIZE-1:0] bjp_seq_incr(input logic rv32);
        return rv32 ? `E203_PC_SIZE'(`E203_BJP_INCR_RV32)
                    : `E203_PC_SIZE'(`E203_BJP_INCR_RV16);
    endfunction

endpackage

// File: rtl/e203_exu_bjp_resolve_if.sv
// rtl/e203_exu_bjp_resolve_if.sv - commit handshake and IFU flush bundle
`include "e203_defines.v"

interface e203_exu_bjp_resolve_if;
    logic                     cmt_i_valid;
    logic                     cmt_i_ready;
    logic                     cmt_i_bjp;
    logic                     cmt_i_fencei;
    logic                     cmt_i_prdt_taken;
    logic                     cmt_i_rslv_taken;
    logic                     cmt_i_rv32;
    logic [`E203_PC_SIZE-1:0] cmt_i_pc;
    logic [`E203_XLEN-1:0]    cmt_i_imm;

    logic                     brchmis_flush_req;
    logic                     brchmis_flush_ack;
    logic [`E203_PC_SIZE-1:0] brchmis_flush_add_op1;
    logic [`E203_PC_SIZE-1:0] brchmis_flush_add_op2;

    modport master (
        output cmt_i_valid, cmt_i_bjp, cmt_i_fencei, cmt_i_prdt_taken,
               cmt_i_rslv_taken, cmt_i_rv32, cmt_i_pc, cmt_i_imm,
               brchmis_flush_ack,
        input  cmt_i_ready, brchmis_flush_req,
               brchmis_flush_add_op1, brchmis_flush_add_op2
    );

    modport slave (
        input  cmt_i_valid, cmt_i_bjp, cmt_i_fencei, cmt_i_prdt_taken,
               cmt_i_rslv_taken, cmt_i_rv32, cmt_i_pc, cmt_i_imm,
               brchmis_flush_ack,
        output cmt_i_ready, brchmis_flush_req,
               brchmis_flush_add_op1, brchmis_flush_add_op2
    );
endinterface

// File: rtl/e203_defines.v
// rtl/e203_defines.v - core-wide widths, resolve FSM encoding and sequential PC increments
`ifndef E203_DEFINES_V
`define E203_DEFINES_V

`define E203_PC_SIZE          32
`define E203_XLEN             32

`define E203_BJP_STATE_WIDTH  1
`define E203_BJP_STATE_IDLE   1'b0
`define E203_BJP_STATE_FLUSH  1'b1

`define E203_BJP_INCR_RV32    4
`define E203_BJP_INCR_RV16    2

`endif

// File: rtl/e203_exu_satcnt.sv
// rtl/e203_exu_satcnt.sv - 32-bit saturating event counter with synchronous clear
module e203_exu_satcnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Clear wins over a same-cycle increment; the all-ones value sticks.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 32'd0;
        end else if (en && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/e203_exu_bjp_resolve.sv
// rtl/e203_exu_bjp_resolve.sv - commit-stage branch resolution and IFU flush request
// Optional performance counters are built when E203_BJP_PERF_CNT_EN is defined.
`include "e203_defines.v"

module e203_exu_bjp_resolve
    import e203_exu_bjp_resolve_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    e203_exu_bjp_resolve_if.slave bus,
    output logic                  cmt_mispred,
    input  logic                  perf_clr,
    output logic [31:0]           perf_bjp_cnt,
    output logic [31:0]           perf_mis_cnt
);

    bjp_state_e               state_q, state_d;
    logic [`E203_PC_SIZE-1:0] op1_q, op1_d;
    logic [`E203_PC_SIZE-1:0] op2_q, op2_d;
    logic                     accept;
    logic                     mispred;
    logic                     need_flush;

    always_comb begin
        accept     = bus.cmt_i_valid && (state_q == BJP_IDLE);
        mispred    = accept && bus.cmt_i_bjp
                     && (bus.cmt_i_prdt_taken != bus.cmt_i_rslv_taken);
        need_flush = mispred || (accept && bus.cmt_i_fencei);

        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;

        case (state_q)
            BJP_IDLE:  if (need_flush) state_d = BJP_FLUSH;
            BJP_FLUSH: if (bus.brchmis_flush_ack) state_d = BJP_IDLE;
            default:   state_d = BJP_IDLE;
        endcase

        // fence.i never takes the immediate: it refetches the next instruction.
        if (need_flush) begin
            op1_d = bus.cmt_i_pc;
            op2_d = (bus.cmt_i_bjp && bus.cmt_i_rslv_taken)
                    ? bus.cmt_i_imm[`E203_PC_SIZE-1:0]
                    : bjp_seq_incr(bus.cmt_i_rv32);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BJP_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    assign bus.cmt_i_ready           = (state_q == BJP_IDLE);
    assign bus.brchmis_flush_req     = (state_q == BJP_FLUSH);
    assign bus.brchmis_flush_add_op1 = op1_q;
    assign bus.brchmis_flush_add_op2 = op2_q;
    assign cmt_mispred               = mispred;

`ifdef E203_BJP_PERF_CNT_EN
    e203_exu_satcnt u_bjp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .en    (accept && bus.cmt_i_bjp),
        .cnt   (perf_bjp_cnt)
    );

    e203_exu_satcnt u_mis_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .en    (mispred),
        .cnt   (perf_mis_cnt)
    );
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_bjp_cnt    = 32'd0;
    assign perf_mis_cnt    = 32'd0;
`endif

endmodule

// File: doc/e203_exu_bjp_resolve.md
E203_EXU_BJP_RESOLVE -- requirements
Module: e203_exu_bjp_resolve

Interface
REQ-001 clk  input  1  core clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cmt_i_valid  input  1  a resolved instruction is offered for commit.
REQ-004 cmt_i_ready  output  1  commit accepted this cycle when high with cmt_i_valid.
REQ-005 cmt_i_bjp  input  1  offered instruction is jal, jalr or bxx.
REQ-006 cmt_i_fencei  input  1  offered instruction is fence.i.
REQ-007 cmt_i_prdt_taken  input  1  taken/not-taken as predicted in IFU.
REQ-008 cmt_i_rslv_taken  input  1  taken/not-taken as resolved by ALU.
REQ-009 cmt_i_rv32  input  1  instruction is 32-bit; 0 means 16-bit compressed.
REQ-010 cmt_i_pc  input  `E203_PC_SIZE  PC of offered instruction.
REQ-011 cmt_i_imm  input  `E203_XLEN  resolved target offset (jalr: rs1+imm minus pc, pre-computed by ALU).
REQ-012 brchmis_flush_req  output  1  flush/redirect request to IFU.
REQ-013 brchmis_flush_ack  input  1  IFU accepts the flush.
REQ-014 brchmis_flush_add_op1, brchmis_flush_add_op2  output  `E203_PC_SIZE each  redirect target = op1+op2, computed by IFU.
REQ-015 cmt_mispred  output  1  one-cycle pulse per accepted mispredicted bjp.
REQ-016 perf_clr  input  1  synchronous clear of performance counters.
REQ-017 perf_bjp_cnt, perf_mis_cnt  output  32 each  committed-bjp and mispredict counts.

Function
REQ-018 Accept = cmt_i_valid & cmt_i_ready; mispredict = accept & cmt_i_bjp & (cmt_i_prdt_taken ^ cmt_i_rslv_taken); need_flush = mispredict | (accept & cmt_i_fencei).
REQ-019 FSM states IDLE and FLUSH; IDLE->FLUSH on need_flush; FLUSH->IDLE on brchmis_flush_ack; otherwise hold.
REQ-020 cmt_i_ready shall be 1 in IDLE and 0 in FLUSH.
REQ-021 brchmis_flush_req shall be 1 exactly while in FLUSH: asserted the cycle after need_flush, held until the ack cycle inclusive, low the cycle after.
REQ-022 Operands shall be captured on need_flush: op1 = cmt_i_pc; op2 = cmt_i_imm[`E203_PC_SIZE-1:0] if resolved taken; else 4 if cmt_i_rv32, 2 if not; fence.i uses the same not-taken rule.
REQ-023 Operand registers shall hold stable throughout FLUSH and need not change in IDLE.
REQ-024 brchmis_flush_ack in IDLE shall be ignored.
REQ-025 cmt_mispred shall be combinational on mispredict in the accept cycle; fence.i shall not pulse it.
REQ-026 A bjp with matching prediction shall commit with no flush and no stall.

Reset
REQ-027 Reset shall force IDLE, brchmis_flush_req=0, cmt_i_ready=1, operands=0, counters=0, effective immediately, including mid-FLUSH; no pending request survives reset.

Configuration
REQ-028 With E203_BJP_PERF_CNT_EN defined: perf_bjp_cnt increments per accepted bjp, perf_mis_cnt per mispredict; both saturate at 0xFFFF_FFFF; perf_clr has priority over an increment in the same cycle.
REQ-029 Without E203_BJP_PERF_CNT_EN: ports remain; both outputs tied to 0, perf_clr ignored, no counter flops.

Structure
REQ-030 FSM state encoding (width 1) and the 4/2 increment constants shall be defined in e203_defines.v.
REQ-031 Counters shall be two instances of one sub-module e203_exu_satcnt (32-bit saturating, clear, enable).

Verification
REQ-032 bjp pc=0x100, prdt=0, rslv=1, imm=0x40 -> next cycle req=1, op1=0x100, op2=0x40; ready=0 until ack; cmt_mispred pulse once.
REQ-033 bjp pc=0x200, prdt=1, rslv=0, rv32=0 -> op2=2; ack after 3 cycles -> req high 3 cycles, low the cycle after ack, ready=1.
REQ-034 fence.i pc=0x300, rv32=1 -> req with op1=0x300, op2=4; cmt_mispred stays 0.
REQ-035 rst_n low during FLUSH -> req=0 and ready=1 immediately; spurious ack afterwards has no effect.
REQ-036 With E203_BJP_PERF_CNT_EN: counter preloaded to 0xFFFF_FFFE, three mispredicts -> holds 0xFFFF_FFFF; perf_clr with a mispredict same cycle -> 0.
REQ-037 Ten back-to-back correctly predicted bjp -> ten accepts in ten cycles, no req, perf_bjp_cnt=10, perf_mis_cnt=0.
